ct_hpcp_evt_cnt: RTL and testbench

Programmable hardware performance counter (mhpmcounterX datapath) directly downstream of the per-counter event-select register.
- Consumes the 64-bit zero-extended event index from that register.
- Selects one pulse from the PMU event bus and accumulates it in a CNT_WIDTH-bit counter.
- Counter is CSR-writable, supports inhibit, and raises a sticky overflow flag.

---
 rtl/ct_hpcp_pkg.sv | 22 ++
 rtl/ct_hpcp_evt_sel.sv | 46 ++++
 rtl/ct_hpcp_evt_cnt.sv | 111 +++++++++++
 tb/tb_ct_hpcp_evt_cnt.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ct_hpcp_pkg.sv
// ---------------------------------------------------------------------------
// ct_hpcp_pkg
// Constants shared by the hardware performance counter datapath and the
// per-counter event-select register that feeds it.
//   HPMCNT_NUM   : highest legal event index on the PMU event bus
//   HPMEVT_WIDTH : width of the event index field taken from eventx_value
//   CNT_WIDTH    : width of the accumulating counter
//   EVT_IDX_NONE : event index meaning "no event selected"
// ---------------------------------------------------------------------------
package ct_hpcp_pkg;

    localparam int HPMCNT_NUM   = 42;
    localparam int HPMEVT_WIDTH = 6;
    localparam int CNT_WIDTH    = 64;
    localparam int EVT_IDX_NONE = 0;

    // True when an index names a real event on the bus.
    function automatic logic evt_idx_legal(input int idx, input int max_idx);
        return (idx != EVT_IDX_NONE) && (idx <= max_idx);
    endfunction

endpackage

// File: rtl/ct_hpcp_evt_sel.sv
// ---------------------------------------------------------------------------
// ct_hpcp_evt_sel
// Combinational event selection for one performance counter: decodes the
// event index and picks the matching pulse from the PMU event bus, gated by
// the global count enable and this counter's inhibit bit.
// Ports:
//   eventx_value  in  64            event-select register (low field used)
//   hpcp_evt_bus  in  HPMCNT_NUM+1  event pulses, bit k = event k
//   hpcp_cnt_en   in  1             global count enable
//   cntx_inhibit  in  1             inhibit for this counter
//   hit           out 1             selected event fired this cycle
// ---------------------------------------------------------------------------
module ct_hpcp_evt_sel
    import ct_hpcp_pkg::*;
#(
    parameter int HPMCNT_NUM_P   = HPMCNT_NUM,
    parameter int HPMEVT_WIDTH_P = HPMEVT_WIDTH
) (
    input  logic [63:0]           eventx_value,
    input  logic [HPMCNT_NUM_P:0] hpcp_evt_bus,
    input  logic                  hpcp_cnt_en,
    input  logic                  cntx_inhibit,
    output logic                  hit
);

    localparam int BUS_EXT_W = 2 ** HPMEVT_WIDTH_P;

    logic [HPMEVT_WIDTH_P-1:0] sel_idx;
    logic [BUS_EXT_W-1:0]      bus_ext;
    logic                      idx_ok;
    logic                      unused_upper;

    assign sel_idx      = eventx_value[HPMEVT_WIDTH_P-1:0];
    assign unused_upper = ^eventx_value[63:HPMEVT_WIDTH_P];

    // The bus is zero-padded to the full index range so that any index value
    // can be used to select without running off the end of the vector;
    // out-of-range indices are also rejected explicitly by idx_ok.
    always_comb begin
        bus_ext                 = '0;
        bus_ext[HPMCNT_NUM_P:0] = hpcp_evt_bus;
        idx_ok                  = evt_idx_legal(int'(sel_idx), HPMCNT_NUM_P);
        hit                     = bus_ext[sel_idx] & idx_ok & hpcp_cnt_en & ~cntx_inhibit;
    end

endmodule

// File: rtl/ct_hpcp_evt_cnt.sv
// ---------------------------------------------------------------------------
// ct_hpcp_evt_cnt
// Programmable hardware performance counter datapath (mhpmcounterX).
// Stage S1 selects one event pulse and registers it into hit_ff; stage S2
// increments the counter from hit_ff. CSR writes override the increment.
// Optional feature macro: HPCP_CNT_OVF_INT_EN
//   defined   : sticky overflow flag and one-cycle overflow pulse on wrap
//   undefined : overflow outputs tied low, counter wraps silently
// Ports:
//   forever_cpuclk  in  1             clock
//   cpurst          in  1             synchronous active-high reset
//   eventx_value    in  64            event index from event-select register
//   hpcp_evt_bus    in  HPMCNT_NUM+1  event pulses
//   hpcp_cnt_en     in  1             global count enable
//   cntx_inhibit    in  1             counter inhibit
//   cntx_wen        in  1             CSR write strobe
//   hpcp_wdata      in  64            CSR write data
//   cntx_ovf_clr    in  1             clear sticky overflow flag
//   cntx_value      out CNT_WIDTH     counter value
//   cntx_ovf        out 1             sticky overflow flag
//   cntx_ovf_int    out 1             one-cycle overflow pulse
// ---------------------------------------------------------------------------
module ct_hpcp_evt_cnt
    import ct_hpcp_pkg::*;
#(
    parameter int HPMCNT_NUM_P   = HPMCNT_NUM,
    parameter int HPMEVT_WIDTH_P = HPMEVT_WIDTH,
    parameter int CNT_WIDTH_P    = CNT_WIDTH
) (
    input  logic                   forever_cpuclk,
    input  logic                   cpurst,
    input  logic [63:0]            eventx_value,
    input  logic [HPMCNT_NUM_P:0]  hpcp_evt_bus,
    input  logic                   hpcp_cnt_en,
    input  logic                   cntx_inhibit,
    input  logic                   cntx_wen,
    input  logic [63:0]            hpcp_wdata,
    input  logic                   cntx_ovf_clr,
    output logic [CNT_WIDTH_P-1:0] cntx_value,
    output logic                   cntx_ovf,
    output logic                   cntx_ovf_int
);

    logic                   hit;
    logic                   hit_ff;
    logic [CNT_WIDTH_P-1:0] cnt;
    logic                   wrap;

    ct_hpcp_evt_sel #(
        .HPMCNT_NUM_P   (HPMCNT_NUM_P),
        .HPMEVT_WIDTH_P (HPMEVT_WIDTH_P)
    ) u_evt_sel (
        .eventx_value (eventx_value),
        .hpcp_evt_bus (hpcp_evt_bus),
        .hpcp_cnt_en  (hpcp_cnt_en),
        .cntx_inhibit (cntx_inhibit),
        .hit          (hit)
    );

    // A wrap only happens through an increment; a CSR write in the same
    // cycle wins and drops the pending hit, so it cannot wrap.
    assign wrap = hit_ff & ~cntx_wen & (&cnt);

    // S1 registers the selected pulse; S2 accumulates it. Inhibit and the
    // count enable act only on S1, so a hit already in hit_ff still counts.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            hit_ff <= 1'b0;
            cnt    <= '0;
        end else begin
            hit_ff <= hit;
            if (cntx_wen) begin
                cnt <= hpcp_wdata[CNT_WIDTH_P-1:0];
            end else if (hit_ff) begin
                cnt <= cnt + CNT_WIDTH_P'(1);
            end
        end
    end

    assign cntx_value = cnt;

`ifdef HPCP_CNT_OVF_INT_EN
    logic ovf_ff;
    logic ovf_int_ff;

    // Sticky flag: a wrap in the same cycle as a clear leaves the flag set.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            ovf_ff     <= 1'b0;
            ovf_int_ff <= 1'b0;
        end else begin
            ovf_int_ff <= wrap;
            if (wrap) begin
                ovf_ff <= 1'b1;
            end else if (cntx_ovf_clr) begin
                ovf_ff <= 1'b0;
            end
        end
    end

    assign cntx_ovf     = ovf_ff;
    assign cntx_ovf_int = ovf_int_ff;
`else
    logic unused_ovf;

    assign unused_ovf   = cntx_ovf_clr ^ wrap;
    assign cntx_ovf     = 1'b0;
    assign cntx_ovf_int = 1'b0;
`endif

endmodule

// File: tb/tb_ct_hpcp_evt_cnt.sv
// ---------------------------------------------------------------------------
// tb_ct_hpcp_evt_cnt
// Directed testbench for ct_hpcp_evt_cnt. Each stimulus vector carries the
// hand-computed counter/overflow state expected right after the clock edge
// that samples it; a separate monitor pops those expectations and compares.
// ---------------------------------------------------------------------------
module tb_ct_hpcp_evt_cnt;
    import ct_hpcp_pkg::*;

`ifdef HPCP_CNT_OVF_INT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct {
        logic [CNT_WIDTH-1:0] val;
        logic                 ovf;
        logic                 ovf_int;
        string                name;
    } exp_t;

    logic                   forever_cpuclk;
    logic                   cpurst;
    logic [63:0]            eventx_value;
    logic [HPMCNT_NUM:0]    hpcp_evt_bus;
    logic                   hpcp_cnt_en;
    logic                   cntx_inhibit;
    logic                   cntx_wen;
    logic [63:0]            hpcp_wdata;
    logic                   cntx_ovf_clr;
    logic [CNT_WIDTH-1:0]   cntx_value;
    logic                   cntx_ovf;
    logic                   cntx_ovf_int;

    exp_t sb_q[$];
    int   assert_count = 0;
    int   fail_count   = 0;

    logic [HPMCNT_NUM:0] bus_all;
    logic [HPMCNT_NUM:0] bus_none;
    logic [63:0]         ones64;

    ct_hpcp_evt_cnt dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .eventx_value   (eventx_value),
        .hpcp_evt_bus   (hpcp_evt_bus),
        .hpcp_cnt_en    (hpcp_cnt_en),
        .cntx_inhibit   (cntx_inhibit),
        .cntx_wen       (cntx_wen),
        .hpcp_wdata     (hpcp_wdata),
        .cntx_ovf_clr   (cntx_ovf_clr),
        .cntx_value     (cntx_value),
        .cntx_ovf       (cntx_ovf),
        .cntx_ovf_int   (cntx_ovf_int)
    );

    initial begin
        forever_cpuclk = 1'b0;
        forever #5 forever_cpuclk = ~forever_cpuclk;
    end

    function automatic logic [HPMCNT_NUM:0] bus_bit(input int k);
        logic [HPMCNT_NUM:0] r;
        r    = '0;
        r[k] = 1'b1;
        return r;
    endfunction

    // Drive one cycle of inputs, queue the state expected after the next
    // rising edge, then move to 2 time units past that edge.
    task automatic applyStimulus(
        input logic                 rst,
        input logic [63:0]          idx,
        input logic [HPMCNT_NUM:0]  bus,
        input logic                 en,
        input logic                 inh,
        input logic                 wen,
        input logic [63:0]          wdata,
        input logic                 clr,
        input logic [CNT_WIDTH-1:0] exp_val,
        input logic                 exp_ovf,
        input logic                 exp_int,
        input string                name
    );
        exp_t e;
        cpurst       = rst;
        eventx_value = idx;
        hpcp_evt_bus = bus;
        hpcp_cnt_en  = en;
        cntx_inhibit = inh;
        cntx_wen     = wen;
        hpcp_wdata   = wdata;
        cntx_ovf_clr = clr;
        e.val        = exp_val;
        e.ovf        = exp_ovf & OVF_EN;
        e.ovf_int    = exp_int & OVF_EN;
        e.name       = name;
        sb_q.push_back(e);
        @(posedge forever_cpuclk);
        #2;
    endtask

    task automatic checkOutput(input exp_t e);
        assert_count++;
        if (cntx_value !== e.val) begin
            fail_count++;
            $display("[TB] FAIL %s value: got %h expected %h", e.name, cntx_value, e.val);
        end
        assert_count++;
        if (cntx_ovf !== e.ovf) begin
            fail_count++;
            $display("[TB] FAIL %s ovf: got %b expected %b", e.name, cntx_ovf, e.ovf);
        end
        assert_count++;
        if (cntx_ovf_int !== e.ovf_int) begin
            fail_count++;
            $display("[TB] FAIL %s ovf_int: got %b expected %b", e.name, cntx_ovf_int, e.ovf_int);
        end
    endtask

    // Monitor samples 1 time unit after each rising edge, before the next
    // vector is driven, and checks the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge forever_cpuclk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        bus_all      = '1;
        bus_none     = '0;
        ones64       = '1;
        cpurst       = 1'b0;
        eventx_value = '0;
        hpcp_evt_bus = '0;
        hpcp_cnt_en  = 1'b0;
        cntx_inhibit = 1'b0;
        cntx_wen     = 1'b0;
        hpcp_wdata   = '0;
        cntx_ovf_clr = 1'b0;
        @(posedge forever_cpuclk);
        #2;

        // reset with bus active
        applyStimulus(1, 64'd5, bus_all,  1, 0, 0, 64'd0, 0, 64'd0, 0, 0, "reset");
        applyStimulus(1, 64'd5, bus_all,  1, 0, 0, 64'd0, 0, 64'd0, 0, 0, "reset_hold");
        applyStimulus(0, 64'd5, bus_none, 1, 0, 0, 64'd0, 0, 64'd0, 0, 0, "post_reset");

        // select event 5, three pulses, then event 6 pulses that must not count
        applyStimulus(0, 64'd5, bus_bit(5), 1, 0, 0, 64'd0, 0, 64'd0, 0, 0, "sel_p1");
        applyStimulus(0, 64'd5, bus_bit(5), 1, 0, 0, 64'd0, 0, 64'd1, 0, 0, "sel_p2");
        applyStimulus(0, 64'd5, bus_bit(5), 1, 0, 0, 64'd0, 0, 64'd2, 0, 0, "sel_p3");
        applyStimulus(0, 64'd5, bus_none,   1, 0, 0, 64'd0, 0, 64'd3, 0, 0, "sel_done");
        applyStimulus(0, 64'd5, bus_bit(6), 1, 0, 0, 64'd0, 0, 64'd3, 0, 0, "other_evt1");
        applyStimulus(0, 64'd5, bus_bit(6), 1, 0, 0, 64'd0, 0, 64'd3, 0, 0, "other_evt2");
        applyStimulus(0, 64'd5, bus_none,   1, 0, 0, 64'd0, 0, 64'd3, 0, 0, "other_evt3");

        // illegal indices with every bus bit high
        applyStimulus(0, 64'd43,   bus_all, 1, 0, 0, 64'd0, 0, 64'd3, 0, 0, "idx_43");
        applyStimulus(0, 64'd0,    bus_all, 1, 0, 0, 64'd0, 0, 64'd3, 0, 0, "idx_0");
        applyStimulus(0, 64'h40,   bus_all, 1, 0, 0, 64'd0, 0, 64'd3, 0, 0, "idx_0x40");
        applyStimulus(0, 64'h1000_0000_0000_0005, bus_all, 1, 0, 0, 64'd0, 0, 64'd3, 0, 0, "idx_upper_set");
        applyStimulus(0, 64'd63,   bus_all, 1, 0, 0, 64'd0, 0, 64'd4, 0, 0, "idx_63");
        applyStimulus(0, 64'd0,    bus_none, 1, 0, 0, 64'd0, 0, 64'd4, 0, 0, "idx_quiet");

        // write priority: hit_ff in write cycle dropped, S1 capture counts later
        applyStimulus(0, 64'd5, bus_bit(5), 1, 0, 1, 64'd10,  0, 64'd10,  0, 0, "wr_10");
        applyStimulus(0, 64'd5, bus_bit(5), 1, 0, 1, 64'd100, 0, 64'd100, 0, 0, "wr_100_drop");
        applyStimulus(0, 64'd5, bus_none,   1, 0, 0, 64'd0,   0, 64'd101, 0, 0, "wr_then_inc");
        applyStimulus(0, 64'd5, bus_none,   1, 0, 0, 64'd0,   0, 64'd101, 0, 0, "wr_settle");
        applyStimulus(0, 64'd5, bus_bit(5), 1, 0, 0, 64'd0,   0, 64'd101, 0, 0, "wr2_hit");
        applyStimulus(0, 64'd5, bus_none,   1, 0, 1, 64'd100, 0, 64'd100, 0, 0, "wr2_drop");
        applyStimulus(0, 64'd5, bus_none,   1, 0, 0, 64'd0,   0, 64'd100, 0, 0, "wr2_no_inc");

        // inhibit and count enable block only S1
        applyStimulus(0, 64'd5, bus_bit(5), 1, 0, 0, 64'd0, 0, 64'd100, 0, 0, "inh_hit");
        applyStimulus(0, 64'd5, bus_bit(5), 1, 1, 0, 64'd0, 0, 64'd101, 0, 0, "inh_inflight");
        applyStimulus(0, 64'd5, bus_bit(5), 1, 1, 0, 64'd0, 0, 64'd101, 0, 0, "inh_block");
        applyStimulus(0, 64'd5, bus_bit(5), 0, 0, 0, 64'd0, 0, 64'd101, 0, 0, "en_off1");
        applyStimulus(0, 64'd5, bus_bit(5), 0, 0, 0, 64'd0, 0, 64'd101, 0, 0, "en_off2");
        applyStimulus(0, 64'd5, bus_none,   1, 0, 0, 64'd0, 0, 64'd101, 0, 0, "en_off3");

        // overflow via two increments from all-ones minus one
        applyStimulus(0, 64'd5, bus_none,   1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, "ovf_wr");
        applyStimulus(0, 64'd5, bus_bit(5), 1, 0, 0, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, "ovf_h1");
        applyStimulus(0, 64'd5, bus_bit(5), 1, 0, 0, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, "ovf_ff");
        applyStimulus(0, 64'd5, bus_none,   1, 0, 0, 64'd0, 0, 64'd0, 1, 1, "ovf_wrap");
        applyStimulus(0, 64'd5, bus_none,   1, 0, 0, 64'd0, 0, 64'd0, 1, 0, "ovf_sticky");
        applyStimulus(0, 64'd5, bus_none,   1, 0, 0, 64'd0, 1, 64'd0, 0, 0, "ovf_clr");

        // write of all-ones alone does not overflow
        applyStimulus(0, 64'd5, bus_none,   1, 0, 1, ones64, 0, ones64, 0, 0, "wr_ones");
        applyStimulus(0, 64'd5, bus_none,   1, 0, 0, 64'd0,  0, ones64, 0, 0, "wr_ones_hold");

        // clear coincident with a wrap: set wins
        applyStimulus(0, 64'd5, bus_bit(5), 1, 0, 0, 64'd0,  0, ones64, 0, 0, "cw_hit");
        applyStimulus(0, 64'd5, bus_none,   1, 0, 0, 64'd0,  0, 64'd0,  1, 1, "cw_wrap1");
        applyStimulus(0, 64'd5, bus_bit(5), 1, 0, 1, ones64, 0, ones64, 1, 0, "cw_wr_ones");
        applyStimulus(0, 64'd5, bus_none,   1, 0, 0, 64'd0,  1, 64'd0,  1, 1, "cw_clr_wrap");
        applyStimulus(0, 64'd5, bus_none,   1, 0, 0, 64'd0,  0, 64'd0,  1, 0, "cw_sticky");
        applyStimulus(0, 64'd5, bus_none,   1, 0, 0, 64'd0,  1, 64'd0,  0, 0, "cw_clr");

        // reset discards an in-flight hit
        applyStimulus(0, 64'd5, bus_bit(5), 1, 0, 0, 64'd0, 0, 64'd0, 0, 0, "rst_pre_hit");
        applyStimulus(1, 64'd5, bus_none,   1, 0, 0, 64'd0, 0, 64'd0, 0, 0, "rst_mid");
        applyStimulus(0, 64'd5, bus_none,   1, 0, 0, 64'd0, 0, 64'd0, 0, 0, "rst_dropped");

        // every queued expectation must have been consumed by the monitor
        assert_count++;
        if (sb_q.size() != 0) begin
            fail_count++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
